// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers,
// with full/almostfull flow control and saturating wr_ack/overflow error counters.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [CNT_WIDTH-1:0]          ack_miss_cnt,
  output logic [CNT_WIDTH-1:0]          ovf_cnt,
  output logic                          err
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      rr_ptr;
  logic                  expect_ack;
  logic                  can_issue;
  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  logic [NUM_REQ-1:0]    grant;
  logic [FIFO_WIDTH-1:0] win_data;
  logic                  transfer;
  logic                  ack_miss;
  int unsigned           cand;

  // A write already on the bus to an almost-full FIFO would fill it, so hold off one cycle.
  assign can_issue = enable && !fifo_full && !(fifo_almostfull && fifo_wr_en);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req_valid[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    grant    = '0;
    win_data = '0;
    if (rst_n && can_issue && win_found) grant[win_idx] = 1'b1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  assign req_ready = grant;
  assign transfer  = |grant;
  assign ack_miss  = expect_ack ^ fifo_wr_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      grant_id     <= '0;
      rr_ptr       <= '0;
      expect_ack   <= 1'b0;
      ack_miss_cnt <= '0;
      ovf_cnt      <= '0;
      err          <= 1'b0;
    end else begin
      fifo_wr_en <= transfer;
      expect_ack <= fifo_wr_en;
      if (transfer) begin
        fifo_data_in <= win_data;
        grant_id     <= win_idx;
        rr_ptr       <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      if (ack_miss && ack_miss_cnt != '1) ack_miss_cnt <= ack_miss_cnt + 1'b1;
      if (fifo_overflow && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
      err <= ack_miss || fifo_overflow;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter driving a depth-8 FIFO flag model with
// optional forced ack/overflow faults.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [15:0] fifo_data_in;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic        fifo_almostfull;
  logic        fifo_wr_ack;
  logic        fifo_overflow;
  logic [1:0]  grant_id;
  logic [7:0]  ack_miss_cnt;
  logic [7:0]  ovf_cnt;
  logic        err;

  logic        rd_en;
  logic        ack_kill;
  logic        ack_force;
  logic        ovf_force;
  logic [3:0]  count;
  logic        ack_q;
  logic        ovf_q;
  logic        wr_ok;
  logic        rd_ok;

  int checks = 0;
  int errors = 0;
  int wcount;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.FIFO_WIDTH(16), .NUM_REQ(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .grant_id(grant_id), .ack_miss_cnt(ack_miss_cnt), .ovf_cnt(ovf_cnt), .err(err)
  );

  // Depth-8 FIFO occupancy model
  assign fifo_full       = (count == 4'd8);
  assign fifo_almostfull = (count == 4'd7);
  assign wr_ok           = fifo_wr_en && !fifo_full;
  assign rd_ok           = rd_en && (count != 4'd0);
  assign fifo_wr_ack     = (ack_q && !ack_kill) || ack_force;
  assign fifo_overflow   = ovf_q || ovf_force;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      count <= count + 4'(wr_ok) - 4'(rd_ok);
      ack_q <= wr_ok;
      ovf_q <= fifo_wr_en && fifo_full;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; req_valid = 4'hF; rd_en = 1'b1;
    ack_kill = 1'b0; ack_force = 1'b0; ovf_force = 1'b0;
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    // Reset state
    repeat (3) step();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("rst_ack_cnt", 32'(ack_miss_cnt), 32'h0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_data", 32'(fifo_data_in), 32'h0);

    // Fairness: all valid, reading every cycle
    rst_n = 1'b1;
    settle();
    for (int k = 0; k < 8; k++) begin
      check("fair_ready", 32'(req_ready), 32'(1 << (k % 4)));
      step();
      check("fair_gid", 32'(grant_id), 32'(k % 4));
      check("fair_wr_en", 32'(fifo_wr_en), 32'h1);
      check("fair_data", 32'(fifo_data_in), 32'(16'h1111 * ((k % 4) + 1)));
    end
    check("fair_ack_cnt", 32'(ack_miss_cnt), 32'h0);

    // Single requester wins every cycle
    req_valid = 4'b0100;
    settle();
    for (int k = 0; k < 10; k++) begin
      step();
      check("single_gid", 32'(grant_id), 32'h2);
      check("single_wr_en", 32'(fifo_wr_en), 32'h1);
    end
    req_valid = 4'b1001;
    settle();
    check("after_single_ready", 32'(req_ready), 32'b1000);
    step();
    check("after_single_gid", 32'(grant_id), 32'h3);
    settle();
    check("wrap_ready", 32'(req_ready), 32'b0001);

    // Drain, then stall against a full FIFO with no reads
    req_valid = 4'b0000;
    repeat (4) step();
    rd_en = 1'b0;
    req_valid = 4'b0001;
    wcount = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (fifo_wr_en) wcount++;
    end
    check("stall_writes", 32'(wcount), 32'd8);
    check("stall_ready", 32'(req_ready), 32'h0);
    check("stall_ovf_cnt", 32'(ovf_cnt), 32'h0);
    check("stall_ack_cnt", 32'(ack_miss_cnt), 32'h0);

    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    wcount = (fifo_wr_en) ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (fifo_wr_en) wcount++;
    end
    check("one_read_writes", 32'(wcount), 32'd1);
    check("one_read_ovf_cnt", 32'(ovf_cnt), 32'h0);

    // Drain, then one write whose ack is suppressed
    req_valid = 4'b0000;
    rd_en = 1'b1;
    repeat (10) step();
    req_valid = 4'b0001;
    step();
    check("ackm_wr_en", 32'(fifo_wr_en), 32'h1);
    req_valid = 4'b0000;
    ack_kill = 1'b1;
    step();
    check("ackm_pre_cnt", 32'(ack_miss_cnt), 32'h0);
    check("ackm_pre_err", 32'(err), 32'h0);
    step();
    ack_kill = 1'b0;
    check("ackm_cnt", 32'(ack_miss_cnt), 32'h1);
    check("ackm_err", 32'(err), 32'h1);
    step();
    check("ackm_err_pulse", 32'(err), 32'h0);
    check("ackm_cnt_hold", 32'(ack_miss_cnt), 32'h1);

    // Spurious acks saturate the counter
    ack_force = 1'b1;
    repeat (300) step();
    check("sat_cnt", 32'(ack_miss_cnt), 32'd255);
    check("sat_err", 32'(err), 32'h1);
    ack_force = 1'b0;
    step();
    check("sat_err_clear", 32'(err), 32'h0);
    check("sat_cnt_hold", 32'(ack_miss_cnt), 32'd255);

    // Forced overflow, then simultaneous overflow and miss
    ovf_force = 1'b1;
    repeat (3) step();
    ovf_force = 1'b0;
    check("ovf_cnt", 32'(ovf_cnt), 32'd3);
    check("ovf_err", 32'(err), 32'h1);
    step();
    check("ovf_err_clear", 32'(err), 32'h0);
    ovf_force = 1'b1;
    ack_force = 1'b1;
    step();
    ovf_force = 1'b0;
    ack_force = 1'b0;
    check("both_ovf_cnt", 32'(ovf_cnt), 32'd4);
    check("both_ack_cnt", 32'(ack_miss_cnt), 32'd255);
    check("both_err", 32'(err), 32'h1);
    step();
    check("both_err_clear", 32'(err), 32'h0);

    // Enable drop during continuous traffic
    req_valid = 4'hF;
    repeat (3) step();
    check("en_gid", 32'(grant_id), 32'h3);
    check("en_wr_en", 32'(fifo_wr_en), 32'h1);
    enable = 1'b0;
    settle();
    check("dis_ready", 32'(req_ready), 32'h0);
    step();
    check("dis_wr_en", 32'(fifo_wr_en), 32'h0);
    check("dis_ack", 32'(fifo_wr_ack), 32'h1);
    check("dis_gid_hold", 32'(grant_id), 32'h3);
    step();
    check("dis_err", 32'(err), 32'h0);
    enable = 1'b1;
    settle();
    check("reen_ready", 32'(req_ready), 32'b0001);
    step();
    step();
    check("reen_gid", 32'(grant_id), 32'h1);
    check("reen_wr_en", 32'(fifo_wr_en), 32'h1);

    // Asynchronous reset mid-burst
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("arst_ready", 32'(req_ready), 32'h0);
    check("arst_gid", 32'(grant_id), 32'h0);
    check("arst_data", 32'(fifo_data_in), 32'h0);
    check("arst_ack_cnt", 32'(ack_miss_cnt), 32'h0);
    check("arst_ovf_cnt", 32'(ovf_cnt), 32'h0);
    step();
    rst_n = 1'b1;
    settle();
    check("post_rst_ready", 32'(req_ready), 32'b0001);
    step();
    check("post_rst_gid", 32'(grant_id), 32'h0);
    check("post_rst_data", 32'(fifo_data_in), 32'h1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
